seg_scan_ctrl: RTL

Time-multiplexing controller that shares one hex-to-seven-segment decoder across a multi-digit common-anode display. It accepts a packed hex word through a valid/ready load port and double-buffers it so updates land only on frame boundaries. It then scans the digits one at a time, inserting a blanking gap between digits to suppress ghosting. It sits between register/datapath logic producing hex values and the board-level anode/segment pins.

---
 rtl/seg_scan_pkg.sv | 24 ++
 rtl/hex7_lut.sv | 13 +
 rtl/seg_scan_ctrl.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package seg_scan_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        DRIVE
    } scan_state_e;

    localparam logic [6:0] SEG_OFF = 7'b1111111;

    // Active-low segment patterns, bit 6 = a ... bit 0 = g, indexed by nibble.
    localparam logic [6:0] HEX7_TABLE [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/hex7_lut.sv
// Combinational nibble to active-low seven-segment lookup.
module hex7_lut
    import seg_scan_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = HEX7_TABLE[nib_i];
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller with double-buffered hex load.
// Optional leading-zero blanking is compiled in with `define SEG_SCAN_LZB_EN.
module seg_scan_ctrl
    import seg_scan_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 8,
    parameter int unsigned TICK_DIV     = 100000,
    parameter int unsigned BLANK_CYCLES = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic                      load_valid,
    output logic                      load_ready,
    input  logic [4*NUM_DIGITS-1:0]   load_data,
    input  logic [NUM_DIGITS-1:0]     dp_mask,
    output logic [NUM_DIGITS-1:0]     an,
    output logic [6:0]                seg,
    output logic                      dp,
    output logic                      frame_done
);

    localparam int unsigned CNT_W = $clog2(max_u(TICK_DIV, BLANK_CYCLES));
    localparam int unsigned IDX_W = $clog2(NUM_DIGITS);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] TICK_LAST  = CNT_W'(TICK_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    scan_state_e state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
    logic [4*NUM_DIGITS-1:0] pend_q, pend_d;
    logic [NUM_DIGITS-1:0]   dp_shadow_q, dp_shadow_d;
    logic [NUM_DIGITS-1:0]   dp_pend_q, dp_pend_d;
    logic                    pend_full_q, pend_full_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic                    frame_done_q, frame_done_d;

    logic                    boundary;
    logic                    xfer;
    logic                    copy;
    logic [3:0]              cur_nib;
    logic [6:0]              cur_seg;
    logic [NUM_DIGITS-1:0]   lz_blank;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        boundary     = 1'b0;
        frame_done_d = 1'b0;
        if (!enable) begin
            state_d = IDLE;
            idx_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = BLANK;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
                BLANK: begin
                    if (cnt_q == BLANK_LAST) begin
                        state_d = DRIVE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                DRIVE: begin
                    if (cnt_q == TICK_LAST) begin
                        state_d = BLANK;
                        cnt_d   = '0;
                        if (idx_q == IDX_LAST) begin
                            idx_d        = '0;
                            boundary     = 1'b1;
                            frame_done_d = 1'b1;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Handshake and copy are mutually exclusive: one needs pending empty, the other full.
    always_comb begin
        xfer        = load_valid && !pend_full_q;
        copy        = pend_full_q && ((state_q == IDLE) || boundary);
        pend_d      = xfer ? load_data : pend_q;
        dp_pend_d   = xfer ? dp_mask : dp_pend_q;
        shadow_d    = copy ? pend_q : shadow_q;
        dp_shadow_d = copy ? dp_pend_q : dp_shadow_q;
        pend_full_d = pend_full_q;
        if (xfer) begin
            pend_full_d = 1'b1;
        end else if (copy) begin
            pend_full_d = 1'b0;
        end
    end

`ifdef SEG_SCAN_LZB_EN
    always_comb begin
        logic run;
        lz_blank = '0;
        run      = 1'b1;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            run = run && (shadow_q[4*(NUM_DIGITS-1-k) +: 4] == 4'h0);
            if (k != NUM_DIGITS - 1) begin
                lz_blank[NUM_DIGITS-1-k] = run;
            end
        end
    end
`else
    assign lz_blank = '0;
`endif

    // Shadow never changes on an edge that enters DRIVE, so shadow_q is valid here.
    assign cur_nib = shadow_q[{idx_d, 2'b00} +: 4];

    hex7_lut u_hex7_lut (
        .nib_i (cur_nib),
        .seg_o (cur_seg)
    );

    always_comb begin
        an_d  = '1;
        seg_d = SEG_OFF;
        dp_d  = 1'b1;
        if (state_d == DRIVE) begin
            an_d[idx_d] = lz_blank[idx_d];
            seg_d       = cur_seg;
            dp_d        = !dp_shadow_q[idx_d];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            cnt_q        <= '0;
            shadow_q     <= '0;
            pend_q       <= '0;
            dp_shadow_q  <= '0;
            dp_pend_q    <= '0;
            pend_full_q  <= 1'b0;
            an_q         <= '1;
            seg_q        <= SEG_OFF;
            dp_q         <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            shadow_q     <= shadow_d;
            pend_q       <= pend_d;
            dp_shadow_q  <= dp_shadow_d;
            dp_pend_q    <= dp_pend_d;
            pend_full_q  <= pend_full_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign frame_done = frame_done_q;
    assign load_ready = !pend_full_q;

endmodule
